// File: rtl/fp_stream_accumulator_pkg.sv
// Shared single-precision constants, FSM encodings and field helpers used by
// the stream accumulator and its adder.
package fp_stream_accumulator_pkg;

  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic fp_sign(input logic [31:0] v);
    return v[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] v);
    return v[30:23];
  endfunction

  function automatic logic [22:0] fp_mant(input logic [31:0] v);
    return v[22:0];
  endfunction

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (fp_exp(v) == FP_EXP_MAX) && (fp_mant(v) != 23'd0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] v);
    return (fp_exp(v) == FP_EXP_MAX) && (fp_mant(v) == 23'd0);
  endfunction

endpackage

// File: rtl/fp_stream_accumulator_fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// gradual underflow, any NaN result returned as the canonical quiet NaN.
module FP_adder
  import fp_stream_accumulator_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out
);

  function automatic logic [31:0] fp_add(input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  d;
    logic [26:0] mx;
    logic [26:0] my;
    logic [27:0] s;
    logic [9:0]  e;
    logic        stk;
    logic        up;
    logic [24:0] r;
    if (fp_is_nan(pa) || fp_is_nan(pb)) return FP_QNAN;
    if (fp_is_inf(pa)) begin
      if (fp_is_inf(pb) && (fp_sign(pa) != fp_sign(pb))) return FP_QNAN;
      return pa;
    end
    if (fp_is_inf(pb)) return pb;
    // Order by magnitude so the alignment shift is always non-negative
    if (pa[30:0] >= pb[30:0]) begin
      x = pa;
      y = pb;
    end else begin
      x = pb;
      y = pa;
    end
    ex = (fp_exp(x) == 8'd0) ? 8'd1 : fp_exp(x);
    ey = (fp_exp(y) == 8'd0) ? 8'd1 : fp_exp(y);
    mx = {|fp_exp(x), fp_mant(x), 3'b000};
    my = {|fp_exp(y), fp_mant(y), 3'b000};
    d  = ex - ey;
    if (d >= 8'd27) begin
      stk = |my;
      my  = {26'd0, stk};
    end else begin
      stk = |(my & ((27'd1 << d) - 27'd1));
      my  = (my >> d) | {26'd0, stk};
    end
    e = {2'b00, ex};
    if (fp_sign(x) == fp_sign(y)) s = {1'b0, mx} + {1'b0, my};
    else                          s = {1'b0, mx} - {1'b0, my};
    if (s == 28'd0) return FP_POS_ZERO;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && (e > 10'd1)) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    r  = {1'b0, s[26:3]} + {24'd0, up};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'd1;
    end
    if (!r[23]) e = 10'd0;
    if (e >= 10'd255) return {fp_sign(x), FP_EXP_MAX, 23'd0};
    return {fp_sign(x), e[7:0], r[22:0]};
  endfunction

  assign out = fp_add(a, b);

endmodule

// File: rtl/fp_stream_accumulator.sv
// Streams len single-precision samples through a combinational adder into a
// running sum, with valid/ready on both sides and sticky inf/NaN status.
module fp_stream_accumulator
  import fp_stream_accumulator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [31:0]      sum_data,
  output logic             busy,
  output logic             inf_flag,
  output logic             nan_flag
);

  state_e             state_q, state_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               first_q, first_d;
  logic               inf_q, inf_d;
  logic               nan_q, nan_d;
  logic [31:0]        add_out;
  logic [31:0]        new_val;
  logic               accept;

  FP_adder u_adder (
    .a   (acc_q),
    .b   (in_data),
    .out (add_out)
  );

  assign accept  = (state_q == S_ACCUM) && in_valid;
  // The first sample bypasses the adder so it never sees a zero seed
  assign new_val = first_q ? in_data : add_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= FP_POS_ZERO;
      cnt_q   <= '0;
      first_q <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (len != '0) ? S_ACCUM : S_DONE;
      S_ACCUM: if (accept && (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1})) state_d = S_DONE;
      S_DONE:  if (sum_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    inf_d   = inf_q;
    nan_d   = nan_q;
    if ((state_q == S_IDLE) && start) begin
      inf_d = 1'b0;
      nan_d = 1'b0;
      if (len != '0) begin
        cnt_d   = len;
        first_d = 1'b1;
      end else begin
        acc_d = FP_POS_ZERO;
      end
    end else if (accept) begin
      cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      first_d = 1'b0;
      if (nan_q || fp_is_nan(in_data) || fp_is_nan(new_val)) begin
        nan_d = 1'b1;
        acc_d = FP_QNAN;
      end else begin
        acc_d = new_val;
        if (fp_is_inf(new_val)) inf_d = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == S_ACCUM);
    sum_valid = (state_q == S_DONE);
    busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
    sum_data  = acc_q;
    inf_flag  = inf_q;
    nan_flag  = nan_q;
  end

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Directed bench for fp_stream_accumulator with hand-computed sums.
module tb_fp_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sum_valid;
  logic        sum_ready;
  logic [31:0] sum_data;
  logic        busy;
  logic        inf_flag;
  logic        nan_flag;

  int checks = 0;
  int errors = 0;

  fp_stream_accumulator #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .busy      (busy),
    .inf_flag  (inf_flag),
    .nan_flag  (nan_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_sum(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 32'h0;
  endtask

  task automatic consume();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    check({tag, "_sum_valid"}, {31'd0, sum_valid}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_inf"},       {31'd0, inf_flag},  32'd0);
    check({tag, "_nan"},       {31'd0, nan_flag},  32'd0);
    check({tag, "_sum_data"},  sum_data,           32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 32'h0; sum_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // 3.875 + 3.5 = 7.375
    start_sum(8'd2);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send(32'h4078_0000);
    check("t1_mid_valid", {31'd0, sum_valid}, 32'd0);
    send(32'h4060_0000);
    check("t1_valid", {31'd0, sum_valid}, 32'd1);
    check("t1_sum", sum_data, 32'h40EC_0000);
    check("t1_nan", {31'd0, nan_flag}, 32'd0);
    check("t1_inf", {31'd0, inf_flag}, 32'd0);
    consume();
    check("t1_idle_valid", {31'd0, sum_valid}, 32'd0);
    check("t1_idle_busy", {31'd0, busy}, 32'd0);

    // 1 + 2 - 0.5 = 2.5 with stalls between samples
    start_sum(8'd3);
    send(32'h3F80_0000);
    tick(); check("t2_stall_rdy_a", {31'd0, in_ready}, 32'd1);
    tick(); check("t2_stall_rdy_b", {31'd0, in_ready}, 32'd1);
    send(32'h4000_0000);
    tick(); check("t2_stall_rdy_c", {31'd0, in_ready}, 32'd1);
    check("t2_stall_acc", sum_data, 32'h4040_0000);
    tick(); check("t2_stall_rdy_d", {31'd0, in_ready}, 32'd1);
    send(32'hBF00_0000);
    check("t2_valid", {31'd0, sum_valid}, 32'd1);
    check("t2_sum", sum_data, 32'h4020_0000);
    check("t2_done_rdy", {31'd0, in_ready}, 32'd0);
    consume();

    // inf + inf = inf
    start_sum(8'd2);
    send(32'h7F80_0000);
    send(32'h7F80_0000);
    check("t3_sum", sum_data, 32'h7F80_0000);
    check("t3_inf", {31'd0, inf_flag}, 32'd1);
    check("t3_nan", {31'd0, nan_flag}, 32'd0);
    consume();
    check("t3_idle_inf_held", {31'd0, inf_flag}, 32'd1);

    // NaN input poisons the sum
    start_sum(8'd3);
    check("t4_inf_cleared", {31'd0, inf_flag}, 32'd0);
    send(32'h3F80_0000);
    send(32'h7FC0_0001);
    check("t4_mid_nan", {31'd0, nan_flag}, 32'd1);
    send(32'h3F80_0000);
    check("t4_sum", sum_data, 32'h7FC0_0000);
    check("t4_nan", {31'd0, nan_flag}, 32'd1);
    check("t4_inf", {31'd0, inf_flag}, 32'd0);
    consume();

    // len = 0 goes straight to DONE and holds while sum_ready is low
    start_sum(8'd0);
    check("t5_valid", {31'd0, sum_valid}, 32'd1);
    check("t5_sum", sum_data, 32'd0);
    check("t5_nan_cleared", {31'd0, nan_flag}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_valid", {31'd0, sum_valid}, 32'd1);
      check("t5_hold_sum", sum_data, 32'd0);
    end
    consume();
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_idle_valid", {31'd0, sum_valid}, 32'd0);

    // reset mid-sum aborts, then a fresh single-sample sum
    start_sum(8'd4);
    send(32'h3F80_0000);
    send(32'h4000_0000);
    check("t6_partial", sum_data, 32'h4040_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t6_rst");
    start_sum(8'd1);
    send(32'h4040_0000);
    check("t6_valid", {31'd0, sum_valid}, 32'd1);
    check("t6_sum", sum_data, 32'h4040_0000);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
